sm_operand_sequencer: RTL and testbench
=======================================

SM_OPERAND_SEQUENCER -- requirements
Module: sm_operand_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, operand FIFO entries (power of two, at least 2).
REQ-002 Parameter: MUL_LATENCY, 10, cycles from the start pulse to a valid product.
REQ-003 Port: clk  input  1  clock, all state on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high; the multiplier shares the same clk and rst.
REQ-005 Port: in_valid  input  1  operand pair offered.
REQ-006 Port: in_ready  output  1  operand pair accepted when in_valid is also high.
REQ-007 Port: in_a  input  4  multiplier operand.
REQ-008 Port: in_b  input  4  multiplicand operand.
REQ-009 Port: start  output  1  one-cycle start pulse to the multiplier.
REQ-010 Port: multiplier  output  4  operand to the multiplier.
REQ-011 Port: multiplicand  output  4  operand to the multiplier.
REQ-012 Port: product  input  8  product from the multiplier.
REQ-013 Port: res_valid  output  1  result available.
REQ-014 Port: res_ready  input  1  consumer accepts the result.
REQ-015 Port: res_product  output  8  captured product.
REQ-016 Port: res_a, res_b  output  4 each  operands belonging to res_product.
REQ-017 Port: busy  output  1  high when the FSM is not IDLE or the FIFO is not empty.

Function
REQ-018 Input fire = in_valid and in_ready; output fire = res_valid and res_ready.
REQ-019 Input fire pushes {in_a, in_b} into the FIFO; FIFO order is preserved end to end.
REQ-020 in_ready = FIFO not full, combinational from the count only; no push/pop bypass when full.
REQ-021 A push and a pop in the same cycle leave the count unchanged; pointers wrap modulo DEPTH.
REQ-022 FSM states: IDLE, START, WAIT, HOLD.
REQ-023 IDLE: when the FIFO is not empty, pop the head into the operand registers and go to START; otherwise stay in IDLE.
REQ-024 START: start=1 for exactly this cycle, load the wait counter with MUL_LATENCY, go to WAIT.
REQ-025 WAIT: decrement the counter each cycle; in the cycle the counter equals 1, capture product, res_a and res_b, set res_valid, and go to HOLD.
REQ-026 HOLD: res_valid=1 with stable res_* outputs until output fire, then clear res_valid and go to IDLE.
REQ-027 multiplier and multiplicand hold the popped operands from START through the end of WAIT and are never changed while start is high.
REQ-028 start is 0 in every state except START; the multiplier never sees two starts within MUL_LATENCY cycles.
REQ-029 Latency: input fire at edge of cycle 0 gives start high in cycle 2 and res_valid high in cycle MUL_LATENCY+3 (13 at the default).
REQ-030 The FIFO keeps accepting pairs during WAIT and HOLD; back-to-back jobs cost one IDLE cycle between them.
REQ-031 res_ready high while res_valid is low has no effect.

Reset
REQ-032 Reset sets: FSM to IDLE, FIFO pointers and count to 0, wait counter to 0, start=0, res_valid=0, multiplier, multiplicand and res_* to 0.
REQ-033 After reset, busy=0 and in_ready=1.
REQ-034 Reset during any state discards all queued and in-flight jobs; no result is produced for them.

Structure
REQ-035 A shared package holds the FSM state enum, the default DEPTH and MUL_LATENCY constants, and the operand and product widths.
REQ-036 The FIFO is one sub-module, sm_operand_fifo, with 8-bit data, push/pop controls, full/empty flags and a count.

Verification
REQ-037 Push 3x5 in cycle 0 with res_ready=1: start pulses in cycle 2; res_valid in cycle 13 with res_product=15, res_a=3, res_b=5.
REQ-038 Push 15x15, then 0x9: results are 225 then 0, in that order, one start each.
REQ-039 Hold res_ready=0 and push 6 pairs back to back: 5 are accepted, then in_ready=0, and in_ready returns to 1 one cycle after the first output fire.
REQ-040 Assert rst during WAIT of 7x7: outputs take reset values at once, and no res_valid appears afterwards.
REQ-041 Push 8 random pairs under random res_ready backpressure: every result equals a*b, order is preserved, and start is never high twice within 10 cycles.

Source files
------------

// File: rtl/sm_operand_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm_operand_sequencer_pkg
//  Description : Shared types and constants for the operand sequencer.
//                Holds the FSM state encoding, the default FIFO depth, the
//                default multiplier latency and the datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sm_operand_sequencer_pkg;

  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_MUL_LATENCY = 10;
  localparam int OPND_W              = 4;
  localparam int PROD_W              = 2 * OPND_W;
  localparam int PAIR_W              = 2 * OPND_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage : sm_operand_sequencer_pkg
`default_nettype wire

// File: rtl/sm_operand_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sm_operand_fifo
//  Description : Small synchronous FIFO for packed operand pairs.
//                Read data is the head entry, valid whenever empty_o is low.
//                Pushes while full and pops while empty are ignored.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                push_i/push_data_i - write strobe and data
//                pop_i/pop_data_o   - read strobe and head data
//                full_o, empty_o    - status flags derived from the count
//                count_o            - number of stored entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_operand_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // No bypass path: a push into a full FIFO is dropped even if a pop
  // happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : sm_operand_fifo
`default_nettype wire

// File: rtl/sm_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sm_operand_sequencer
//  Description : Queues operand pairs and feeds them one at a time to a
//                fixed-latency multiplier, then presents each product with
//                its operands on a valid/ready result interface.
//  Ports       : clk, rst                 - clock, asynchronous active-high reset
//                in_valid/in_ready        - operand pair handshake
//                in_a, in_b               - operand pair
//                start                    - one-cycle pulse to the multiplier
//                multiplier, multiplicand - operands held for the multiplier
//                product                  - multiplier result
//                res_valid/res_ready      - result handshake
//                res_product, res_a, res_b- captured result and its operands
//                busy                     - work queued or in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_operand_sequencer
  import sm_operand_sequencer_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  output logic              start,
  output logic [OPND_W-1:0] multiplier,
  output logic [OPND_W-1:0] multiplicand,
  input  logic [PROD_W-1:0] product,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_product,
  output logic [OPND_W-1:0] res_a,
  output logic [OPND_W-1:0] res_b,
  output logic              busy
);

  localparam int CNT_W  = $clog2(MUL_LATENCY + 1);
  localparam int FCNT_W = $clog2(DEPTH) + 1;

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [OPND_W-1:0] op_a_q;
  logic [OPND_W-1:0] op_b_q;
  logic [PROD_W-1:0] res_prod_q;
  logic [OPND_W-1:0] res_a_q;
  logic [OPND_W-1:0] res_b_q;
  logic              res_valid_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [PAIR_W-1:0] fifo_rdata;
  logic              fifo_push;

  logic              pop_en;
  logic              capture_en;
  logic              wait_last;

  // --------------------------------------------------------------------------
  // Operand queue
  // --------------------------------------------------------------------------
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  sm_operand_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (PAIR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({in_a, in_b}),
    .pop_i       (pop_en),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Counter reaches 1 in the cycle the multiplier output becomes valid.
  assign wait_last = (wait_cnt_q == CNT_W'(1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (wait_last) state_d = ST_HOLD;
      ST_HOLD:  if (res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    start      = 1'b0;
    pop_en     = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      ST_IDLE:  pop_en     = !fifo_empty;
      ST_START: start      = 1'b1;
      ST_WAIT:  capture_en = wait_last;
      default:  ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: wait counter, operand and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_prod_q  <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (start) begin
        wait_cnt_q <= CNT_W'(MUL_LATENCY);
      end else if (state_q == ST_WAIT) begin
        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
      end

      // Operands only change on a pop in IDLE, so they are stable for the
      // whole START/WAIT window the multiplier depends on.
      if (pop_en) begin
        {op_a_q, op_b_q} <= fifo_rdata;
      end

      if (capture_en) begin
        res_prod_q  <= product;
        res_a_q     <= op_a_q;
        res_b_q     <= op_b_q;
        res_valid_q <= 1'b1;
      end else if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign multiplier   = op_a_q;
  assign multiplicand = op_b_q;
  assign res_valid    = res_valid_q;
  assign res_product  = res_prod_q;
  assign res_a        = res_a_q;
  assign res_b        = res_b_q;
  assign busy         = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule : sm_operand_sequencer
`default_nettype wire

// File: tb/tb_sm_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_operand_sequencer
//  Description : Self-checking bench for sm_operand_sequencer. Models the
//                fixed-latency multiplier, keeps a job scoreboard and runs
//                directed, table-driven and randomized sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_operand_sequencer;

  localparam int LAT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic       start;
  logic [3:0] multiplier;
  logic [3:0] multiplicand;
  logic [7:0] product;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_product;
  logic [3:0] res_a;
  logic [3:0] res_b;
  logic       busy;

  always #5 clk = ~clk;

  sm_operand_sequencer #(
    .DEPTH       (4),
    .MUL_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .start        (start),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_product  (res_product),
    .res_a        (res_a),
    .res_b        (res_b),
    .busy         (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Multiplier model: product is correct only in the single cycle that is
  // LAT cycles after the start pulse; otherwise it carries the complement.
  // --------------------------------------------------------------------------
  int         m_cnt;
  logic [7:0] m_prod;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_prod <= 8'd0;
    end else if (start) begin
      m_cnt  <= LAT;
      m_prod <= multiplier * multiplicand;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign product = (m_cnt == 1) ? m_prod : ~m_prod;

  // --------------------------------------------------------------------------
  // Scoreboard: jobs enter on input fire, leave on output fire, in order.
  // --------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  logic [7:0] pr;
  int         fires = 0;
  int         starts = 0;
  int         last_start = -1000;
  int         ea, eb;
  logic       hold_pend = 1'b0;
  logic [7:0] hp;
  logic [3:0] ha, hb;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_start = -1000;
      hold_pend  = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", res_valid, 1);
        check("hold_product", res_product, hp);
        check("hold_a", res_a, ha);
        check("hold_b", res_b, hb);
      end
      hold_pend = res_valid && !res_ready;
      hp = res_product;
      ha = res_a;
      hb = res_b;

      if (start) begin
        starts++;
        check("start_spacing_ok", (cyc - last_start) >= LAT, 1);
        last_start = cyc;
      end

      if (in_valid && in_ready) exp_q.push_back({in_a, in_b});

      if (res_valid && res_ready) begin
        fires++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: result %0d with no job outstanding", res_product);
        end else begin
          pr = exp_q.pop_front();
          ea = int'(pr[7:4]);
          eb = int'(pr[3:0]);
          check("sb_product", res_product, ea * eb);
          check("sb_a", res_a, ea);
          check("sb_b", res_b, eb);
        end
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready still 0, required 1 (a=%0d b=%0d)", a, b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int t0, n, s0, f0;
    logic seen_valid, seen_start;

    tbl[0] = {4'd15, 4'd15, 8'd225};
    tbl[1] = {4'd0,  4'd9,  8'd0};
    tbl[2] = {4'd7,  4'd7,  8'd49};
    tbl[3] = {4'd1,  4'd15, 8'd15};
    tbl[4] = {4'd12, 4'd11, 8'd132};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_multiplier", multiplier, 0);
    check("rst_multiplicand", multiplicand, 0);
    check("rst_res_product", res_product, 0);
    check("rst_res_a", res_a, 0);
    check("rst_res_b", res_b, 0);
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // ---------------- latency: 3x5 ----------------
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 4'd3;
    in_b      = 4'd5;
    t0        = cyc;
    check("lat_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!start && n < 50) begin tick(); n++; end
    check("lat_start_cycle", cyc - t0, 2);
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    check("lat_res_valid_cycle", cyc - t0, LAT + 3);
    check("lat_product", res_product, 15);
    check("lat_res_a", res_a, 3);
    check("lat_res_b", res_b, 5);
    tick();

    // ---------------- table-driven back-to-back jobs ----------------
    s0 = starts;
    for (int i = 0; i < 5; i++) push(tbl[i].a, tbl[i].b);
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!res_valid && n < 100) begin tick(); n++; end
      check("tbl_product", res_product, tbl[i].prod);
      check("tbl_res_a", res_a, tbl[i].a);
      check("tbl_res_b", res_b, tbl[i].b);
      tick();
    end
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("tbl_one_start_each", starts - s0, 5);

    // ---------------- backpressure fills the FIFO ----------------
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a     = 4'(i + 1);
      in_b     = 4'(i + 2);
      check("bp_in_ready", in_ready, (i < 5) ? 1 : 0);
      if (i < 5) tick();
    end
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    check("bp_first_result", res_valid, 1);
    check("bp_full_at_result", in_ready, 0);
    repeat (3) tick();
    check("bp_still_full", in_ready, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_ready_after_fire_idle", in_ready, 0);
    tick();
    check("bp_ready_returns", in_ready, 1);
    tick();
    in_valid  = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while (busy && n < 500) begin tick(); n++; end
    check("bp_drained", exp_q.size(), 0);
    check("bp_idle", busy, 0);

    // ---------------- reset during WAIT ----------------
    push(4'd7, 4'd7);
    push(4'd2, 4'd3);
    n = 0;
    while (!start && n < 50) begin tick(); n++; end
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_start", start, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_multiplier", multiplier, 0);
    check("arst_multiplicand", multiplicand, 0);
    check("arst_res_product", res_product, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    seen_valid = 1'b0;
    seen_start = 1'b0;
    repeat (40) begin
      tick();
      seen_valid = seen_valid | res_valid;
      seen_start = seen_start | start;
    end
    check("arst_no_result", seen_valid, 0);
    check("arst_no_start", seen_start, 0);

    // ---------------- random jobs under random backpressure ----------------
    f0 = fires;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
      end
      begin
        int k = 0;
        while ((fires - f0) < 8 && k < 3000) begin
          res_ready = 1'($urandom_range(0, 1));
          tick();
          k++;
        end
        res_ready = 1'b0;
      end
    join
    check("rand_results", fires - f0, 8);
    check("rand_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sm_operand_sequencer
`default_nettype wire
